// File: rtl/i2c_target_regs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_target_regs                                              |
// | Description : I2C target with pointer + burst register-file port; SCL/SDA  |
// |               oversampled by clk, SDA driven as open-drain low-enable.     |
// |               Define I2C_SPIKE_FILTER_EN for a 3-sample majority filter.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR    = 7'h48,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_oe,
  output logic [$clog2(NUM_REGS)-1:0] reg_addr,
  output logic [7:0]                  reg_wdata,
  output logic                        reg_wr_en,
  input  logic [7:0]                  reg_rdata,
  output logic                        busy
);
  localparam int            AW       = $clog2(NUM_REGS);
  localparam logic [AW-1:0] LAST_REG = AW'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ADDR     = 4'd1,
    S_ADDR_ACK = 4'd2,
    S_PTR      = 4'd3,
    S_PTR_ACK  = 4'd4,
    S_WR       = 4'd5,
    S_WR_ACK   = 4'd6,
    S_RD       = 4'd7,
    S_RD_ACK   = 4'd8
  } state_t;

  // Synchronizers reset to 1 so an idle bus produces no edge after reset.
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    end
  end

  logic scl_s, sda_s;
`ifdef I2C_SPIKE_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[SYNC_STAGES-1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[SYNC_STAGES-1]};
    end
  end
  assign scl_s = (scl_sync_q[SYNC_STAGES-1] & scl_hist_q[0]) |
                 (scl_sync_q[SYNC_STAGES-1] & scl_hist_q[1]) |
                 (scl_hist_q[0] & scl_hist_q[1]);
  assign sda_s = (sda_sync_q[SYNC_STAGES-1] & sda_hist_q[0]) |
                 (sda_sync_q[SYNC_STAGES-1] & sda_hist_q[1]) |
                 (sda_hist_q[0] & sda_hist_q[1]);
`else
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
`endif

  logic scl_prev_q, sda_prev_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s &  scl_prev_q;
  // SCL must be high in both samples so a simultaneous SCL fall is not a bus condition.
  assign start_det = scl_s & scl_prev_q & ~sda_s &  sda_prev_q;
  assign stop_det  = scl_s & scl_prev_q &  sda_s & ~sda_prev_q;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    tx_q, tx_d;
  logic          rw_q, rw_d;
  logic          mack_q, mack_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] addr_inc;

  assign addr_inc = (addr_q == LAST_REG) ? '0 : addr_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    rw_d     = rw_q;
    mack_d   = mack_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_en_d  = 1'b0;
    if (wr_en_q) addr_d = addr_inc;
    if (stop_det) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      cnt_d    = '0;
    end else if (start_det) begin
      state_d  = S_ADDR;
      sda_oe_d = 1'b0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ADDR, S_PTR, S_WR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            if (state_q == S_ADDR) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                rw_d     = shift_q[0];
                state_d  = S_ADDR_ACK;
              end else begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
              end
            end else if (state_q == S_PTR) begin
              if (32'(shift_q) < NUM_REGS) begin
                sda_oe_d = 1'b1;
                addr_d   = shift_q[AW-1:0];
                state_d  = S_PTR_ACK;
              end else begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
              end
            end else begin
              wdata_d  = shift_q;
              wr_en_d  = 1'b1;
              sda_oe_d = 1'b1;
              state_d  = S_WR_ACK;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              tx_d     = {reg_rdata[6:0], 1'b0};
              sda_oe_d = ~reg_rdata[7];
              state_d  = S_RD;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_PTR;
            end
          end
        end
        S_PTR_ACK, S_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = S_WR;
          end
        end
        S_RD: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              cnt_d    = '0;
              sda_oe_d = 1'b0;
              state_d  = S_RD_ACK;
            end else begin
              sda_oe_d = ~tx_q[7];
              tx_d     = {tx_q[6:0], 1'b0};
            end
          end
        end
        S_RD_ACK: begin
          // Pointer advances at the ACK rise so reg_rdata already reflects it at the fall.
          if (scl_rise) begin
            mack_d = sda_s;
            if (!sda_s) addr_d = addr_inc;
          end else if (scl_fall) begin
            if (!mack_q) begin
              tx_d     = {reg_rdata[6:0], 1'b0};
              sda_oe_d = ~reg_rdata[7];
              state_d  = S_RD;
            end else begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      tx_q     <= '0;
      rw_q     <= 1'b0;
      mack_q   <= 1'b1;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      rw_q     <= rw_d;
      mack_q   <= mack_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_en_q  <= wr_en_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr_en = wr_en_q;
endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
`default_nettype none
// Testbench for i2c_target_regs: bit-banged I2C master, bench-side register file,
// transaction-level model of pointer/memory, per-cycle strobe and SDA-timing checks.
module tb_i2c_target_regs;
  localparam int NUM_REGS = 16;
  localparam int Q        = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe, reg_wr_en, busy;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;
  logic       sda_line;

  logic [7:0]  mem [NUM_REGS];
  logic [7:0]  model_mem [NUM_REGS];
  bit          mem_init = 1'b1;
  int          model_ptr = 0;
  logic [11:0] exp_wr_q [$];
  logic [11:0] wr_log [$];
  logic [7:0]  rd_log [$];
  logic [11:0] exp_e;
  int          checks = 0;
  int          failures = 0;
  bit          oe_zero_req = 1'b0;
  bit          suppress = 1'b0;
  logic        prev_oe = 1'b0;

  assign sda_line  = sda_m & ~sda_oe;
  assign reg_rdata = mem[reg_addr];

  always #5 clk = ~clk;

  i2c_target_regs #(.DEV_ADDR(7'h48), .NUM_REGS(NUM_REGS), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_i     (scl),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr_en (reg_wr_en),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= 8'(i * 17) ^ 8'h3C;
    end else if (reg_wr_en) begin
      mem[reg_addr] <= reg_wdata;
    end
  end

  // Per-cycle compare against the transaction model.
  always @(negedge clk) begin
    if (reset_n && !suppress) begin
      if (reg_wr_en) begin
        checks++;
        if (exp_wr_q.size() == 0) begin
          failures++;
          $display("FAIL wr_strobe: unexpected write addr=%0d data=%02h", reg_addr, reg_wdata);
        end else begin
          exp_e = exp_wr_q.pop_front();
          if ({reg_addr, reg_wdata} !== exp_e) begin
            failures++;
            $display("FAIL wr_strobe: got addr/data %03h required %03h", {reg_addr, reg_wdata}, exp_e);
          end
        end
        wr_log.push_back({reg_addr, reg_wdata});
      end
      if (oe_zero_req) begin
        checks++;
        if (sda_oe !== 1'b0) begin
          failures++;
          $display("FAIL oe_zero: sda_oe=%b required 0", sda_oe);
        end
      end
      if (sda_oe !== prev_oe) begin
        checks++;
        if (scl !== 1'b0) begin
          failures++;
          $display("FAIL oe_timing: sda_oe changed to %b while scl=%b, required scl=0", sda_oe, scl);
        end
      end
    end
    prev_oe <= sda_oe;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q);
  endtask

  task automatic send_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      wait_clk(Q); sda_m = d[7-i];
      wait_clk(Q); scl = 1'b1;
      wait_clk(2*Q); scl = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    send_bits(d, 8);
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q); scl = 1'b1;
    wait_clk(2); ack = sda_line;
    wait_clk(2*Q-2); scl = 1'b0;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    d = '0;
    for (int i = 0; i < 8; i++) begin
      wait_clk(Q); sda_m = 1'b1;
      wait_clk(Q); scl = 1'b1;
      wait_clk(2); d = {d[6:0], sda_line};
      wait_clk(2*Q-2); scl = 1'b0;
    end
    wait_clk(Q); sda_m = mack;
    wait_clk(Q); scl = 1'b1;
    wait_clk(2*Q); scl = 1'b0;
  endtask

  task automatic end_checks();
    wait_clk(4);
    check("busy_idle", busy, 0);
    check("reg_addr", reg_addr, model_ptr);
    check("wr_pending", exp_wr_q.size(), 0);
  endtask

  task automatic write_txn(input logic [7:0] ptr, input int n, input logic [31:0] data_word);
    logic a;
    logic [7:0] d;
    i2c_start();
    send_byte(8'h90, a);
    check("addr_ack", a, 0);
    check("busy_on", busy, 1);
    send_byte(ptr, a);
    if (ptr < NUM_REGS) begin
      check("ptr_ack", a, 0);
      model_ptr = ptr;
      for (int i = 0; i < n; i++) begin
        d = data_word[31-8*i -: 8];
        exp_wr_q.push_back({4'(model_ptr), d});
        model_mem[model_ptr] = d;
        model_ptr = (model_ptr + 1) % NUM_REGS;
        send_byte(d, a);
        check("data_ack", a, 0);
      end
    end else begin
      check("ptr_nack", a, 1);
      check("busy_after_nack", busy, 0);
    end
    i2c_stop();
    end_checks();
  endtask

  task automatic read_txn(input bit set_ptr, input logic [7:0] ptr, input int n);
    logic a;
    logic [7:0] d;
    i2c_start();
    if (set_ptr) begin
      send_byte(8'h90, a);
      check("addr_ack", a, 0);
      send_byte(ptr, a);
      check("ptr_ack", a, 0);
      model_ptr = ptr;
      i2c_start();
    end
    send_byte(8'h91, a);
    check("rd_addr_ack", a, 0);
    check("busy_on", busy, 1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, d);
      rd_log.push_back(d);
      check("rd_data", d, model_mem[model_ptr]);
      if (i != n - 1) model_ptr = (model_ptr + 1) % NUM_REGS;
    end
    wait_clk(4);
    check("oe_after_nack", sda_oe, 0);
    i2c_stop();
    end_checks();
  endtask

  task automatic mismatch_txn(input logic [7:0] ab);
    logic a;
    oe_zero_req = 1'b1;
    i2c_start();
    send_byte(ab, a);
    check("mismatch_nack", a, 1);
    check("mismatch_busy", busy, 0);
    oe_zero_req = 1'b0;
    i2c_stop();
    end_checks();
  endtask

  task automatic abort_txn(input logic [7:0] ptr, input int nbits);
    logic a;
    i2c_start();
    send_byte(8'h90, a);
    check("addr_ack", a, 0);
    send_byte(ptr, a);
    check("ptr_ack", a, 0);
    model_ptr = ptr;
    send_bits(8'($urandom), nbits);
    i2c_stop();
    end_checks();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    logic a;
    logic [7:0] b;
    int r;
    for (int i = 0; i < NUM_REGS; i++) model_mem[i] = 8'(i * 17) ^ 8'h3C;
    wait_clk(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_wr_en", reg_wr_en, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_busy", busy, 0);
    mem_init = 1'b0;
    reset_n = 1'b1;
    wait_clk(4);

    // Directed write: ptr 3, A5, 5A
    write_txn(8'h03, 2, 32'hA55A_0000);
    check("wr_log_len", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      check("wr0_lit", wr_log[0], 12'h3A5);
      check("wr1_lit", wr_log[1], 12'h45A);
    end
    check("addr_after_wr_lit", reg_addr, 5);

    // Directed read with wrap from reg 15 to reg 0
    rd_log.delete();
    read_txn(1'b1, 8'h0F, 2);
    check("rd_log_len", rd_log.size(), 2);
    if (rd_log.size() == 2) begin
      check("rd0_lit", rd_log[0], 8'hC3);
      check("rd1_lit", rd_log[1], 8'h3C);
    end
    check("addr_after_rd_lit", reg_addr, 0);

    mismatch_txn(8'hA0);
    write_txn(8'h10, 1, 32'hFF00_0000);
    abort_txn(8'h07, 4);

    for (int it = 0; it < 20; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        b = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
        write_txn(b, $urandom_range(1, 4), $urandom);
      end else if (r <= 6 || r == 9) begin
        read_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom_range(1, 4));
      end else if (r == 7) begin
        b = 8'($urandom);
        if (b[7:1] == 7'h48) b = b ^ 8'h80;
        mismatch_txn(b);
      end else begin
        abort_txn(8'($urandom_range(0, 15)), $urandom_range(1, 7));
      end
    end

    // Reset mid-read: reg 5 holds 0x00 so the first read bit pulls SDA low
    write_txn(8'h05, 1, 32'h0000_0000);
    i2c_start();
    send_byte(8'h90, a);
    send_byte(8'h05, a);
    model_ptr = 5;
    i2c_start();
    send_byte(8'h91, a);
    wait_clk(5);
    check("rd_bit_driven", sda_oe, 1);
    suppress = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("rst_mid_oe", sda_oe, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_addr", reg_addr, 0);
    scl = 1'b1;
    wait_clk(2);
    sda_m = 1'b1;
    wait_clk(4);
    reset_n = 1'b1;
    model_ptr = 0;
    wait_clk(4);
    suppress = 1'b0;

    // One-clock SDA low while SCL high, SCL falls as SDA returns
    wait_clk(4);
    sda_m = 1'b0;
    wait_clk(1);
    sda_m = 1'b1;
    scl = 1'b0;
    send_byte(8'h90, a);
`ifdef I2C_SPIKE_FILTER_EN
    check("glitch_no_start", a, 1);
    check("glitch_busy", busy, 0);
`else
    check("glitch_start", a, 0);
    check("glitch_busy", busy, 1);
`endif
    i2c_stop();
    end_checks();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
